// File: rtl/ahb3lite_interconnect_arb_slave_port.sv
// ahb3lite_interconnect_arb_slave_port
// One slave-side port of the AHB3-Lite multi-layer switch. It picks one of
// MASTERS requesting master ports and routes that master's address phase onto
// the slave bus. The write data of the previous accepted phase follows one
// phase later. Burst and lock boundaries are tracked locally, so ownership
// only moves where the bus protocol allows it.
// Ports:
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   mstpriority              per-master priority (higher wins)
//   mstH*                    per-master address/control/write-data inputs
//   mstHRDATA/READYOUT/RESP  slave responses passed back to the masters
//   slv_H*                   slave bus driven by the current owner
//   slv_HMASTER              index of the address-phase owner
//   granted_master           one-hot grant
//   starved                  masters currently promoted by aging
module ahb3lite_interconnect_arb_slave_port #(
   parameter int HADDR_SIZE    = 32,
   parameter int HDATA_SIZE    = 32,
   parameter int MASTERS       = 3,
   parameter int PRIORITY_BITS = 3,
   parameter int ARB_MODE      = 0,
   parameter int STARVE_LIMIT  = 16
) (
   input  logic                                  HCLK,
   input  logic                                  HRESETn,
   input  logic [MASTERS-1:0][PRIORITY_BITS-1:0] mstpriority,
   input  logic [MASTERS-1:0]                    mstHSEL,
   input  logic [MASTERS-1:0][HADDR_SIZE-1:0]    mstHADDR,
   input  logic [MASTERS-1:0][HDATA_SIZE-1:0]    mstHWDATA,
   input  logic [MASTERS-1:0]                    mstHWRITE,
   input  logic [MASTERS-1:0][2:0]               mstHSIZE,
   input  logic [MASTERS-1:0][2:0]               mstHBURST,
   input  logic [MASTERS-1:0][3:0]               mstHPROT,
   input  logic [MASTERS-1:0][1:0]               mstHTRANS,
   input  logic [MASTERS-1:0]                    mstHMASTLOCK,
   input  logic [MASTERS-1:0]                    mstHREADY,
   output logic [HDATA_SIZE-1:0]                 mstHRDATA,
   output logic                                  mstHREADYOUT,
   output logic                                  mstHRESP,
   output logic                                  slv_HSEL,
   output logic [HADDR_SIZE-1:0]                 slv_HADDR,
   output logic [HDATA_SIZE-1:0]                 slv_HWDATA,
   output logic                                  slv_HWRITE,
   output logic [2:0]                            slv_HSIZE,
   output logic [2:0]                            slv_HBURST,
   output logic [3:0]                            slv_HPROT,
   output logic [1:0]                            slv_HTRANS,
   output logic                                  slv_HMASTLOCK,
   output logic                                  slv_HREADY,
   input  logic [HDATA_SIZE-1:0]                 slv_HRDATA,
   input  logic                                  slv_HREADYOUT,
   input  logic                                  slv_HRESP,
   output logic [$clog2(MASTERS)-1:0]            slv_HMASTER,
   output logic [MASTERS-1:0]                    granted_master,
   output logic [MASTERS-1:0]                    starved
);
   localparam int MW   = $clog2(MASTERS);
   localparam int NCLS = (2 ** PRIORITY_BITS) + 1;   // priority levels + promoted class
   localparam int CW   = $clog2(NCLS);
   localparam int WW   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CW-1:0] PROMO_CLS  = CW'(NCLS - 1);
   localparam logic [WW-1:0] WAIT_MAX   = WW'(STARVE_LIMIT);
   localparam logic [1:0]    TR_IDLE    = 2'b00;
   localparam logic [1:0]    TR_NONSEQ  = 2'b10;
   localparam logic [1:0]    TR_SEQ     = 2'b11;

   typedef enum logic [1:0] {OWN_OPEN = 2'b00, OWN_BURST = 2'b01, OWN_LOCKED = 2'b10} own_state_t;

   // Remaining beats after a NONSEQ of the given burst type (0 = no boundary).
   function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
      case (hburst)
         3'b010, 3'b011: burst_beats = 4'd3;
         3'b100, 3'b101: burst_beats = 4'd7;
         3'b110, 3'b111: burst_beats = 4'd15;
         default:        burst_beats = 4'd0;
      endcase
   endfunction

   own_state_t              state_r, state_next_s;
   logic [MW-1:0]           master_r, data_idx_r, winner_s, cand_s;
   logic [MASTERS-1:0]      grant_r, starved_r, starved_next_s;
   logic [MASTERS-1:0]      req_s, promoted_s, member_s;
   logic [3:0]              beats_r, beats_next_s;
   logic                    first_beat_r, found_s, accept_s, switch_s, move_s;
   logic [PRIORITY_BITS-1:0] top_level_s;
   logic [CW-1:0]           cls_s;
   logic [1:0]              own_trans_s;
   logic [MW-1:0]           ptr_r [NCLS];
   logic [WW-1:0]           wait_r [MASTERS];
   logic [WW-1:0]           wait_next_s [MASTERS];

   // Request decode: selected and not IDLE.
   always_comb begin
      req_s = '0;
      for (int m = 0; m < MASTERS; m++) begin
         req_s[m] = mstHSEL[m] && (mstHTRANS[m] != TR_IDLE);
      end
   end

   // Arbitration class: promoted masters first, then top priority (or all in RR mode).
   always_comb begin
      top_level_s = '0;
      member_s    = '0;
      cls_s       = '0;
      promoted_s  = starved_r & req_s;
      for (int m = 0; m < MASTERS; m++) begin
         top_level_s = (req_s[m] && (mstpriority[m] > top_level_s)) ? mstpriority[m] : top_level_s;
      end
      if (|promoted_s) begin
         cls_s    = PROMO_CLS;
         member_s = promoted_s;
      end else if (ARB_MODE != 0) begin
         cls_s    = '0;
         member_s = req_s;
      end else begin
         cls_s = CW'(top_level_s);
         for (int m = 0; m < MASTERS; m++) begin
            member_s[m] = req_s[m] && (mstpriority[m] == top_level_s);
         end
      end
   end

   // Round-robin search inside the class, starting after its last grant.
   always_comb begin
      found_s  = 1'b0;
      winner_s = master_r;
      cand_s   = '0;
      for (int off = 1; off <= MASTERS; off++) begin
         cand_s   = MW'((int'(ptr_r[cls_s]) + off) % MASTERS);
         winner_s = (!found_s && member_s[cand_s]) ? cand_s : winner_s;
         found_s  = found_s | member_s[cand_s];
      end
   end

   // Address/control mux from the owner; the first beat after a switch is forced NONSEQ.
   always_comb begin
      own_trans_s   = mstHTRANS[master_r];
      slv_HSEL      = mstHSEL[master_r];
      slv_HADDR     = mstHADDR[master_r];
      slv_HWRITE    = mstHWRITE[master_r];
      slv_HSIZE     = mstHSIZE[master_r];
      slv_HBURST    = mstHBURST[master_r];
      slv_HPROT     = mstHPROT[master_r];
      slv_HMASTLOCK = mstHMASTLOCK[master_r];
      slv_HREADY    = mstHREADY[master_r];
      slv_HWDATA    = mstHWDATA[data_idx_r];
      if (first_beat_r && (own_trans_s == TR_SEQ)) begin
         slv_HTRANS = TR_NONSEQ;
      end else begin
         slv_HTRANS = own_trans_s;
      end
   end

   assign accept_s       = slv_HREADY && slv_HSEL;
   assign mstHRDATA      = slv_HRDATA;
   assign mstHREADYOUT   = slv_HREADYOUT;
   assign mstHRESP       = slv_HRESP;
   assign slv_HMASTER    = master_r;
   assign granted_master = grant_r;
   assign starved        = starved_r;

   // Beat counter: load on NONSEQ, count down on SEQ, hold otherwise.
   always_comb begin
      beats_next_s = beats_r;
      if (accept_s) begin
         case (slv_HTRANS)
            TR_NONSEQ: beats_next_s = burst_beats(slv_HBURST);
            TR_SEQ:    beats_next_s = (beats_r != 4'd0) ? (beats_r - 4'd1) : beats_r;
            default:   beats_next_s = beats_r;
         endcase
      end else begin
         beats_next_s = beats_r;
      end
   end

   // Ownership FSM next state; only accepted edges (slv_HREADY=1) move it.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         OWN_OPEN, OWN_BURST, OWN_LOCKED: begin
            if (!slv_HREADY) begin
               state_next_s = state_r;
            end else if (slv_HMASTLOCK) begin
               state_next_s = OWN_LOCKED;
            end else if (beats_next_s != 4'd0) begin
               state_next_s = OWN_BURST;
            end else begin
               state_next_s = OWN_OPEN;
            end
         end
         default: state_next_s = OWN_OPEN;
      endcase
   end

   assign switch_s = slv_HREADY && (state_next_s == OWN_OPEN);
   assign move_s   = switch_s && found_s;

   // Aging counters: count while requesting and not owning, saturate at the limit.
   always_comb begin
      starved_next_s = '0;
      for (int m = 0; m < MASTERS; m++) begin
         wait_next_s[m] = '0;
         if (!req_s[m] || grant_r[m]) begin
            wait_next_s[m] = '0;
         end else if (wait_r[m] != WAIT_MAX) begin
            wait_next_s[m] = wait_r[m] + WW'(1);
         end else begin
            wait_next_s[m] = wait_r[m];
         end
         starved_next_s[m] = (STARVE_LIMIT != 0) && (wait_next_s[m] == WAIT_MAX);
      end
   end

   // Grant, data-phase index, beat counter, FSM and first-beat flag.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_r      <= OWN_OPEN;
         master_r     <= '0;
         grant_r      <= {{(MASTERS-1){1'b0}}, 1'b1};
         data_idx_r   <= '0;
         beats_r      <= 4'd0;
         first_beat_r <= 1'b0;
      end else begin
         state_r <= state_next_s;
         beats_r <= beats_next_s;
         if (slv_HREADY) begin
            data_idx_r <= master_r;
         end
         if (move_s) begin
            master_r <= winner_s;
            grant_r  <= {{(MASTERS-1){1'b0}}, 1'b1} << winner_s;
         end
         if (move_s && (winner_s != master_r)) begin
            first_beat_r <= 1'b1;
         end else if (accept_s && slv_HTRANS[1]) begin
            first_beat_r <= 1'b0;
         end
      end
   end

   // Per-class round-robin pointers, updated only when a grant is issued.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int c = 0; c < NCLS; c++) begin
            ptr_r[c] <= '0;
         end
      end else if (move_s) begin
         ptr_r[cls_s] <= winner_s;
      end
   end

   // Aging state; counts every cycle, independent of wait states.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         starved_r <= '0;
         for (int m = 0; m < MASTERS; m++) begin
            wait_r[m] <= '0;
         end
      end else begin
         starved_r <= starved_next_s;
         for (int m = 0; m < MASTERS; m++) begin
            wait_r[m] <= wait_next_s[m];
         end
      end
   end
endmodule
